// File: rtl/backend_pipe_ctrl_pkg.sv
// Shared types and helpers for the backend stall/clear sequencer.
// Vectors are indexed {m2, m1, ex} per pipe, pipe 0 = main, pipe 1 = sub.
package backend_pipe_ctrl_pkg;

  localparam int unsigned NumPipes  = 2;
  localparam int unsigned NumStages = 3;

  localparam int unsigned StageEx = 0;
  localparam int unsigned StageM1 = 1;
  localparam int unsigned StageM2 = 2;

  typedef enum logic [1:0] {
    StRun,
    StHold,
    StRedir
  } pipe_ctrl_state_t;

  typedef logic [NumStages-1:0] stage_vec_t;
  typedef stage_vec_t [NumPipes-1:0] pipe_vec_t;

  // A stall in any stage also freezes every older-numbered stage behind it.
  function automatic stage_vec_t merge_stall(input pipe_vec_t req);
    stage_vec_t any_req;
    stage_vec_t s;
    any_req = req[0] | req[1];
    s[StageM2] = any_req[StageM2];
    s[StageM1] = any_req[StageM2] | any_req[StageM1];
    s[StageEx] = |any_req;
    return s;
  endfunction

  // Bubble into stage k+1 only if that stage actually advances.
  function automatic stage_vec_t clr_gate(input stage_vec_t s);
    return ~{s[StageM2], s[StageM2], s[StageM1]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with asynchronous active-low reset.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/backend_pipe_ctrl.sv
// Central stall/clear sequencer for the main and sub backend pipelines.
// Merges stall requests, orders ex flushes and m2 redirects, and counts events.
module backend_pipe_ctrl
  import backend_pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned REDIR_GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0][2:0]      stall_req_i,
  input  logic [1:0]           ex_clr_req_i,
  input  logic [1:0]           m2_clr_req_i,
  input  logic [1:0]           m2_clr_excl_self_i,
  input  logic [1:0][3:0]      revert_i,
  output logic [1:0][2:0]      stall_vec_o,
  output logic [1:0][2:0]      clr_vec_o,
  output logic                 issue_allow_o,
  output logic                 fe_flush_o,
  output logic                 fe_stall_o,
  output logic [CNT_W-1:0]     perf_stall_o,
  output logic [CNT_W-1:0]     perf_exflush_o,
  output logic [CNT_W-1:0]     perf_redir_o
);

  localparam int unsigned    GapW    = $clog2(REDIR_GAP + 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(REDIR_GAP);

  pipe_ctrl_state_t state_q, state_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             pend_young_q, pend_young_d;

  stage_vec_t s;
  pipe_vec_t  clr;
  logic       redir;
  logic       ex_req;
  logic       ex_young;
  logic       ex_apply;
  logic       ex_peer_clr;
  logic       fe_flush;
  logic       unused_in;

  // Only pipe 0 raises flushes; the remaining bits carry no information here.
  assign unused_in = ^{ex_clr_req_i[1], m2_clr_req_i[1], m2_clr_excl_self_i[1],
                       revert_i[1], revert_i[0][3], revert_i[0][StageM1]};

  assign s        = merge_stall(stall_req_i);
  assign redir    = m2_clr_req_i[0] & ~s[StageM2];
  assign ex_req   = ex_clr_req_i[0];
  assign ex_young = ~revert_i[0][StageEx];

  // Ex flushes are dropped in REDIR: everything younger than m2 is already gone.
  always_comb begin
    ex_apply    = 1'b0;
    ex_peer_clr = 1'b0;
    unique case (state_q)
      StRun: begin
        ex_apply    = ex_req & ~s[StageEx] & ~redir;
        ex_peer_clr = ex_young;
      end
      StHold: begin
        ex_apply    = ~s[StageEx] & ~redir;
        ex_peer_clr = pend_young_q | (ex_req & ex_young);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      gap_q        <= '0;
      pend_young_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      pend_young_q <= pend_young_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    pend_young_d = pend_young_q;
    if (redir) begin
      state_d      = StRedir;
      gap_d        = GapLoad;
      pend_young_d = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_req && s[StageEx]) begin
            state_d      = StHold;
            pend_young_d = ex_young;
          end
        end
        StHold: begin
          if (!s[StageEx]) begin
            state_d      = StRun;
            pend_young_d = 1'b0;
          end else if (ex_req) begin
            pend_young_d = pend_young_q | ex_young;
          end
        end
        StRedir: begin
          if (gap_q <= GapW'(1)) begin
            state_d = StRun;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - GapW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    clr = '0;
    if (redir) begin
      clr[0] = {m2_clr_excl_self_i[0], 2'b11};
      clr[1] = {~revert_i[0][StageM2], 2'b11};
    end else if (ex_apply) begin
      clr[1][StageEx] = ex_peer_clr;
    end
    clr[0]   = clr[0] & clr_gate(s);
    clr[1]   = clr[1] & clr_gate(s);
    fe_flush = redir | ex_apply;

    stall_vec_o   = '0;
    clr_vec_o     = '0;
    issue_allow_o = 1'b0;
    fe_flush_o    = 1'b0;
    fe_stall_o    = 1'b0;
    if (rst_n) begin
      stall_vec_o   = {s, s};
      clr_vec_o     = clr;
      fe_flush_o    = fe_flush;
      fe_stall_o    = s[StageEx];
      issue_allow_o = ~s[StageEx] & (state_q == StRun) & ~fe_flush;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_stall (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(s[StageEx]),
    .cnt_o(perf_stall_o)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_exflush (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(ex_apply),
    .cnt_o(perf_exflush_o)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_redir (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(redir),
    .cnt_o(perf_redir_o)
  );

endmodule

// File: tb/tb_backend_pipe_ctrl.sv
// Bench for backend_pipe_ctrl: vector table for single-cycle behaviour plus
// hand-written sequences for hold, redirect gap, saturation and async reset.
module tb_backend_pipe_ctrl;

  localparam int unsigned CntW     = 4;
  localparam int unsigned RedirGap = 2;

  logic            clk;
  logic            rst_n;
  logic [1:0][2:0] stall_req_i;
  logic [1:0]      ex_clr_req_i;
  logic [1:0]      m2_clr_req_i;
  logic [1:0]      m2_clr_excl_self_i;
  logic [1:0][3:0] revert_i;
  logic [1:0][2:0] stall_vec_o;
  logic [1:0][2:0] clr_vec_o;
  logic            issue_allow_o;
  logic            fe_flush_o;
  logic            fe_stall_o;
  logic [CntW-1:0] perf_stall_o;
  logic [CntW-1:0] perf_exflush_o;
  logic [CntW-1:0] perf_redir_o;

  backend_pipe_ctrl #(
    .CNT_W    (CntW),
    .REDIR_GAP(RedirGap)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_req_i       (stall_req_i),
    .ex_clr_req_i      (ex_clr_req_i),
    .m2_clr_req_i      (m2_clr_req_i),
    .m2_clr_excl_self_i(m2_clr_excl_self_i),
    .revert_i          (revert_i),
    .stall_vec_o       (stall_vec_o),
    .clr_vec_o         (clr_vec_o),
    .issue_allow_o     (issue_allow_o),
    .fe_flush_o        (fe_flush_o),
    .fe_stall_o        (fe_stall_o),
    .perf_stall_o      (perf_stall_o),
    .perf_exflush_o    (perf_exflush_o),
    .perf_redir_o      (perf_redir_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // st = {pipe1 m2,m1,ex, pipe0 m2,m1,ex}; rev = revert_i[0]; e* = expected outputs.
  typedef struct packed {
    logic [5:0] st;
    logic       ex;
    logic       m2;
    logic       excl;
    logic [3:0] rev;
    logic [2:0] es;
    logic [2:0] ec0;
    logic [2:0] ec1;
    logic       ei;
    logic       ef;
    logic       efs;
  } vec_t;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ex;
    logic [3:0] rd;
  } cnt_t;

  int         nvec;
  int         nfail;
  logic [3:0] ec_st, ec_ex, ec_rd;
  cnt_t       cnt_q[$];
  vec_t       tbl[12];

  function automatic vec_t mk(input logic [5:0] st, input logic ex, input logic m2,
                              input logic excl, input logic [3:0] rev, input logic [2:0] es,
                              input logic [2:0] ec0, input logic [2:0] ec1, input logic ei,
                              input logic ef, input logic efs);
    vec_t v;
    v = '{st, ex, m2, excl, rev, es, ec0, ec1, ei, ef, efs};
    return v;
  endfunction

  function automatic vec_t idle(input logic ei);
    return mk(6'b0, 1'b0, 1'b0, 1'b0, 4'b0, 3'b000, 3'b000, 3'b000, ei, 1'b0, 1'b0);
  endfunction

  function automatic logic [3:0] sat(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    nvec++;
    if (got !== req) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_req_i        = v.st;
    ex_clr_req_i       = {1'b0, v.ex};
    m2_clr_req_i       = {1'b0, v.m2};
    m2_clr_excl_self_i = {1'b0, v.excl};
    revert_i           = {4'b0000, v.rev};
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic step(input vec_t v, input string name);
    cnt_t e;
    drive(v);
    #4;
    check({name, " outs"},
          32'({stall_vec_o, clr_vec_o, issue_allow_o, fe_flush_o, fe_stall_o}),
          32'({v.es, v.es, v.ec1, v.ec0, v.ei, v.ef, v.efs}));
    if (v.es[0]) ec_st = sat(ec_st);
    if (v.ef && v.m2) ec_rd = sat(ec_rd);
    if (v.ef && !v.m2) ec_ex = sat(ec_ex);
    cnt_q.push_back({ec_st, ec_ex, ec_rd});
    @(posedge clk);
    #1;
    e = cnt_q.pop_front();
    check({name, " perf"}, 32'({perf_stall_o, perf_exflush_o, perf_redir_o}), 32'(e));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(idle(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ec_st = '0;
    ec_ex = '0;
    ec_rd = '0;
    cnt_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t redir_v;
    int   blocked;
    nvec  = 0;
    nfail = 0;
    ec_st = '0;
    ec_ex = '0;
    ec_rd = '0;

    tbl[0]  = mk(6'b000000, 0, 0, 0, 4'b0000, 3'b000, 3'b000, 3'b000, 1, 0, 0);
    tbl[1]  = mk(6'b100000, 0, 0, 0, 4'b0000, 3'b111, 3'b000, 3'b000, 0, 0, 1);
    tbl[2]  = mk(6'b000010, 0, 0, 0, 4'b0000, 3'b011, 3'b000, 3'b000, 0, 0, 1);
    tbl[3]  = mk(6'b001000, 0, 0, 0, 4'b0000, 3'b001, 3'b000, 3'b000, 0, 0, 1);
    tbl[4]  = mk(6'b000000, 1, 0, 0, 4'b0000, 3'b000, 3'b000, 3'b001, 0, 1, 0);
    tbl[5]  = mk(6'b000000, 1, 0, 0, 4'b0001, 3'b000, 3'b000, 3'b000, 0, 1, 0);
    tbl[6]  = mk(6'b000000, 0, 1, 1, 4'b0000, 3'b000, 3'b111, 3'b111, 0, 1, 0);
    tbl[7]  = mk(6'b000000, 0, 1, 0, 4'b0100, 3'b000, 3'b011, 3'b011, 0, 1, 0);
    tbl[8]  = mk(6'b000100, 0, 1, 1, 4'b0000, 3'b111, 3'b000, 3'b000, 0, 0, 1);
    tbl[9]  = mk(6'b000010, 0, 1, 1, 4'b0000, 3'b011, 3'b110, 3'b110, 0, 1, 1);
    tbl[10] = mk(6'b000000, 1, 1, 0, 4'b0000, 3'b000, 3'b011, 3'b111, 0, 1, 0);
    tbl[11] = mk(6'b000001, 0, 1, 1, 4'b0000, 3'b001, 3'b111, 3'b111, 0, 1, 1);

    // Reset state with every request asserted: outputs must stay quiet.
    rst_n = 1'b0;
    drive(mk(6'b111111, 1, 1, 1, 4'b0000, 3'b0, 3'b0, 3'b0, 0, 0, 0));
    #3;
    check("reset outs", 32'({stall_vec_o, clr_vec_o, issue_allow_o, fe_flush_o, fe_stall_o,
                             perf_stall_o, perf_exflush_o, perf_redir_o}), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(idle(1'b0));

    for (int i = 0; i < 12; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
      blocked = (tbl[i].ef && tbl[i].m2) ? int'(RedirGap) : 0;
      for (int j = 0; j <= int'(RedirGap); j++) begin
        step(idle(j >= blocked), $sformatf("vec%0d settle%0d", i, j));
      end
    end

    // Ex flush under a 3-cycle m1 stall, applied when the stall drops.
    reset_dut();
    step(mk(6'b000010, 1, 0, 0, 4'b0000, 3'b011, 3'b000, 3'b000, 0, 0, 1), "hold c1");
    step(mk(6'b000010, 0, 0, 0, 4'b0000, 3'b011, 3'b000, 3'b000, 0, 0, 1), "hold c2");
    step(mk(6'b000010, 0, 0, 0, 4'b0000, 3'b011, 3'b000, 3'b000, 0, 0, 1), "hold c3");
    step(mk(6'b000000, 0, 0, 0, 4'b0000, 3'b000, 3'b000, 3'b001, 0, 1, 0), "hold apply");
    step(idle(1'b1), "hold after");

    // Redirect gap, then a second redirect inside REDIR reloads the gap.
    reset_dut();
    redir_v = mk(6'b000000, 0, 1, 1, 4'b0000, 3'b000, 3'b111, 3'b111, 0, 1, 0);
    step(redir_v, "redir first");
    step(idle(1'b0), "redir gap1");
    step(redir_v, "redir reload");
    step(idle(1'b0), "reload gap1");
    step(idle(1'b0), "reload gap2");
    step(idle(1'b1), "reload done");

    // Pending ex flush discarded by a redirect arriving while in HOLD.
    reset_dut();
    step(mk(6'b000010, 1, 0, 0, 4'b0000, 3'b011, 3'b000, 3'b000, 0, 0, 1), "drop c1");
    step(mk(6'b000010, 0, 1, 0, 4'b0000, 3'b011, 3'b010, 3'b110, 0, 1, 1), "drop redir");
    step(idle(1'b0), "drop gap1");
    step(idle(1'b0), "drop gap2");
    step(idle(1'b1), "drop no flush");

    // Stall counter saturation.
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      step(mk(6'b100000, 0, 0, 0, 4'b0000, 3'b111, 3'b000, 3'b000, 0, 0, 1),
           $sformatf("sat%0d", i));
    end
    check("sat final", 32'(perf_stall_o), 32'(4'hF));

    // Asynchronous reset in the middle of REDIR.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      step(mk(6'b000001, 0, 0, 0, 4'b0000, 3'b001, 3'b000, 3'b000, 0, 0, 1),
           $sformatf("pre%0d", i));
    end
    step(redir_v, "mid redir");
    step(idle(1'b0), "mid gap1");
    drive(mk(6'b111111, 1, 1, 1, 4'b0000, 3'b0, 3'b0, 3'b0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset", 32'({stall_vec_o, clr_vec_o, issue_allow_o, fe_flush_o, fe_stall_o,
                              perf_stall_o, perf_exflush_o, perf_redir_o}), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ec_st = '0;
    ec_ex = '0;
    ec_rd = '0;
    cnt_q.delete();
    step(idle(1'b1), "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
